// File: rtl/lr_job_sequencer_pkg.sv
// Shared definitions for the leaky-ReLU job sequencer: sequencer state
// encoding and the Q8.8 number-format constants of the leaky-ReLU datapath.
package lr_pkg;

  localparam int                   LR_DATA_W = 16;
  localparam int                   LR_FRAC_W = 8;
  localparam logic [LR_DATA_W-1:0] LR_ONE    = 16'h0100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } lr_seq_state_t;

endpackage

// File: rtl/lr_job_sequencer_if.sv
// Job / row-stream / leaky-ReLU-lane bundle for lr_job_sequencer.
// master: the side issuing jobs, supplying rows and returning result valids.
// slave : the sequencer itself.
interface lr_job_sequencer_if
  import lr_pkg::*;
#(
  parameter int DATA_W = LR_DATA_W,
  parameter int ROW_W  = 16
);

  // job configuration and status
  logic              cfg_start;
  logic [ROW_W-1:0]  cfg_rows;
  logic [DATA_W-1:0] cfg_leak_factor;
  logic              busy;
  logic              done;

  // upstream row stream
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data_1;
  logic [DATA_W-1:0] in_data_2;

  // leaky-ReLU stage drive and result return
  logic [DATA_W-1:0] lr_leak_factor_out;
  logic              lr_valid_1_out;
  logic              lr_valid_2_out;
  logic [DATA_W-1:0] lr_data_1_out;
  logic [DATA_W-1:0] lr_data_2_out;
  logic              res_valid_1_in;
  logic              res_valid_2_in;

  modport master (
    output cfg_start, cfg_rows, cfg_leak_factor,
    output in_valid, in_data_1, in_data_2,
    output res_valid_1_in, res_valid_2_in,
    input  busy, done, in_ready,
    input  lr_leak_factor_out, lr_valid_1_out, lr_valid_2_out,
    input  lr_data_1_out, lr_data_2_out
  );

  modport slave (
    input  cfg_start, cfg_rows, cfg_leak_factor,
    input  in_valid, in_data_1, in_data_2,
    input  res_valid_1_in, res_valid_2_in,
    output busy, done, in_ready,
    output lr_leak_factor_out, lr_valid_1_out, lr_valid_2_out,
    output lr_data_1_out, lr_data_2_out
  );

endinterface

// File: rtl/lr_job_sequencer_skew_stage.sv
// lr_skew_stage: one-cycle valid/data delay that puts lane 2 one cycle
// behind lane 1 to line up with systolic column timing. Data only loads
// with a valid beat so the output holds its last value across bubbles.
module lr_skew_stage
  import lr_pkg::*;
#(
  parameter int DATA_W = LR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // delay the lane by one cycle; data captured only on valid beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lr_job_sequencer.sv
// lr_job_sequencer: sequences one matrix tile through the two-lane leaky-ReLU
// stage. Accepts a job (rows, leak factor), pulls rows from the upstream
// buffer, drives both lanes and counts returned results per lane.
// Build option: define LR_SKEW_EN to delay lane 2 by one extra cycle
// (lr_skew_stage); without it both lanes issue in the same cycle.
// rst is asynchronous and active-low.
module lr_job_sequencer
  import lr_pkg::*;
#(
  parameter int DATA_W = LR_DATA_W,
  parameter int ROW_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  lr_job_sequencer_if.slave   bus
);

  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  lr_seq_state_t     r_state;
  lr_seq_state_t     w_state_next;

  logic [ROW_W-1:0]  r_rows;
  logic [ROW_W-1:0]  r_issued;
  logic [ROW_W-1:0]  r_res_cnt_1;
  logic [ROW_W-1:0]  r_res_cnt_2;
  logic [DATA_W-1:0] r_leak;

  logic              r_valid_1;
  logic              r_valid_2;
  logic [DATA_W-1:0] r_data_1;
  logic [DATA_W-1:0] r_data_2;

  logic              w_start;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_count_en;
  logic              w_res_inc_1;
  logic              w_res_inc_2;
  logic [ROW_W-1:0]  w_res_cnt_1_next;
  logic [ROW_W-1:0]  w_res_cnt_2_next;
  logic              w_res_full;

  // Ready depends on state and issue count only, never on in_valid.
  // issued < rows also keeps the all-ones row count from wrapping.
  assign w_in_ready  = (r_state == ST_STREAM) && (r_issued < r_rows);
  assign w_xfer      = w_in_ready && bus.in_valid;
  // rows >= 1 whenever a transfer is possible, so rows-1 cannot underflow here
  assign w_last_xfer = w_xfer && (r_issued == (r_rows - ROW_ONE));

  // Results are counted only while the job is streaming or draining and
  // saturate at the job's row count; excess pulses are dropped.
  assign w_count_en       = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign w_res_inc_1      = w_count_en && bus.res_valid_1_in && (r_res_cnt_1 < r_rows);
  assign w_res_inc_2      = w_count_en && bus.res_valid_2_in && (r_res_cnt_2 < r_rows);
  assign w_res_cnt_1_next = r_res_cnt_1 + ROW_W'(w_res_inc_1);
  assign w_res_cnt_2_next = r_res_cnt_2 + ROW_W'(w_res_inc_2);
  // Completion looks at the post-increment counts so the final result pulse
  // moves DRAIN to DONE in the same cycle it arrives.
  assign w_res_full       = (w_res_cnt_1_next == r_rows) && (w_res_cnt_2_next == r_rows);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic and start acceptance
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          w_start      = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = (r_rows == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        if (w_last_xfer) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_res_full) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // job registers and counters; start in IDLE latches the job and clears counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rows      <= '0;
      r_leak      <= '0;
      r_issued    <= '0;
      r_res_cnt_1 <= '0;
      r_res_cnt_2 <= '0;
    end else if (w_start) begin
      r_rows      <= bus.cfg_rows;
      r_leak      <= bus.cfg_leak_factor;
      r_issued    <= '0;
      r_res_cnt_1 <= '0;
      r_res_cnt_2 <= '0;
    end else begin
      if (w_xfer) begin
        r_issued <= r_issued + ROW_ONE;
      end
      r_res_cnt_1 <= w_res_cnt_1_next;
      r_res_cnt_2 <= w_res_cnt_2_next;
    end
  end

  // lane issue registers: valid follows each transfer, data holds across bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_1 <= 1'b0;
      r_valid_2 <= 1'b0;
      r_data_1  <= '0;
      r_data_2  <= '0;
    end else begin
      r_valid_1 <= w_xfer;
      r_valid_2 <= w_xfer;
      if (w_xfer) begin
        r_data_1 <= bus.in_data_1;
        r_data_2 <= bus.in_data_2;
      end
    end
  end

  assign bus.busy               = (r_state != ST_IDLE);
  assign bus.done               = (r_state == ST_DONE);
  assign bus.in_ready           = w_in_ready;
  assign bus.lr_leak_factor_out = r_leak;
  assign bus.lr_valid_1_out     = r_valid_1;
  assign bus.lr_data_1_out      = r_data_1;

`ifdef LR_SKEW_EN
  logic              w_valid_2_skew;
  logic [DATA_W-1:0] w_data_2_skew;

  lr_skew_stage #(
    .DATA_W (DATA_W)
  ) u_skew (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_valid_2),
    .i_data  (r_data_2),
    .o_valid (w_valid_2_skew),
    .o_data  (w_data_2_skew)
  );

  assign bus.lr_valid_2_out = w_valid_2_skew;
  assign bus.lr_data_2_out  = w_data_2_skew;
`else
  assign bus.lr_valid_2_out = r_valid_2;
  assign bus.lr_data_2_out  = r_data_2;
`endif

endmodule

// File: tb/tb_lr_job_sequencer.sv
// Self-checking bench for lr_job_sequencer. A job-level reference model
// predicts every output cycle by cycle from the timing rules: transfers happen
// when the model says the sequencer is ready, lane outputs follow transfers by
// 1 (lane 1) and 1 or 2 (lane 2) cycles, the leaky-ReLU stage returns results
// one cycle later, and completion follows the cycle in which both saturated
// result counts reach the row count. Works with or without LR_SKEW_EN.
`timescale 1ns/1ps
module tb_lr_job_sequencer;
  import lr_pkg::*;

  localparam int DATA_W = 16;
  localparam int ROW_W  = 16;
  localparam int MAXR   = 256;
`ifdef LR_SKEW_EN
  localparam int L2 = 2;
`else
  localparam int L2 = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lr_job_sequencer_if #(.DATA_W(DATA_W), .ROW_W(ROW_W)) bus ();

  lr_job_sequencer #(.DATA_W(DATA_W), .ROW_W(ROW_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state carried across jobs
  logic [DATA_W-1:0] m_d1     = '0;
  logic [DATA_W-1:0] m_d2     = '0;
  logic [DATA_W-1:0] m_factor = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    bus.cfg_start      = 1'b0;
    bus.in_valid       = 1'b0;
    bus.res_valid_1_in = 1'b0;
    bus.res_valid_2_in = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"},  bus.busy, 0);
    check({pfx, "_done"},  bus.done, 0);
    check({pfx, "_ready"}, bus.in_ready, 0);
    check({pfx, "_leak"},  bus.lr_leak_factor_out, 0);
    check({pfx, "_v1"},    bus.lr_valid_1_out, 0);
    check({pfx, "_v2"},    bus.lr_valid_2_out, 0);
    check({pfx, "_d1"},    bus.lr_data_1_out, 0);
    check({pfx, "_d2"},    bus.lr_data_2_out, 0);
  endtask

  // One job from the start cycle (r=0) to the idle cycle after done.
  // pat: in_valid for r=2+i when use_pat; inject_r: cycle of an ignored
  // cfg_start; abort_r: cycle at which reset is applied mid-cycle.
  task automatic run_job(input int rows, input logic [DATA_W-1:0] factor,
                         input bit use_pat, input logic [15:0] pat,
                         input bit extra_en, input int inject_r, input int abort_r,
                         output int obs_done_r);
    bit                xfer [MAXR];
    logic [DATA_W-1:0] xd1  [MAXR];
    logic [DATA_W-1:0] xd2  [MAXR];
    int   issued = 0, cnt1 = 0, cnt2 = 0, done_r = -1;
    bit   finished = 1'b0;
    bit   p1, p2, exp_rdy, exp_v1, exp_v2;
    logic [DATA_W-1:0] prev_factor = m_factor;
    obs_done_r = -1;
    for (int r = 0; r < MAXR; r++) begin
      step();
      // stimulus for cycle r
      bus.cfg_start       = (r == 0) || (inject_r > 0 && r == inject_r);
      bus.cfg_rows        = (r == 0) ? ROW_W'(rows) : ROW_W'(9);
      bus.cfg_leak_factor = (r == 0) ? factor : LR_ONE;
      if (use_pat)
        bus.in_valid = (r >= 2 && r - 2 < 16) ? pat[r-2] : 1'b1;
      else
        bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data_1 = DATA_W'($urandom);
      bus.in_data_2 = DATA_W'($urandom);

      // model: readiness and transfer
      exp_rdy = (r >= 2) && (issued < rows);
      xfer[r] = bus.in_valid && exp_rdy;
      xd1[r]  = bus.in_data_1;
      xd2[r]  = bus.in_data_2;
      if (xfer[r]) issued++;

      // model of the leaky-ReLU stage: one cycle after each lane output
      p1 = (r >= 2) && xfer[r-2];
      p2 = (r >= 1 + L2) && xfer[r-1-L2];
      if (extra_en && rows > 0 && cnt1 >= rows && done_r < 0 && $urandom_range(0, 1) == 1)
        p1 = 1'b1;
      bus.res_valid_1_in = p1;
      bus.res_valid_2_in = p2;
      if (r >= 1 && done_r < 0) begin
        cnt1 = (cnt1 + int'(p1) > rows) ? rows : cnt1 + int'(p1);
        cnt2 = (cnt2 + int'(p2) > rows) ? rows : cnt2 + int'(p2);
        if (cnt1 >= rows && cnt2 >= rows) done_r = r + 1;
      end

      // model: lane outputs
      exp_v1 = (r >= 1) && xfer[r-1];
      exp_v2 = (r >= L2) && xfer[r-L2];
      if (exp_v1) m_d1 = xd1[r-1];
      if (exp_v2) m_d2 = xd2[r-L2];

      if (bus.done === 1'b1 && obs_done_r < 0) obs_done_r = r;
      check("busy",  bus.busy, (r >= 1) && (done_r < 0 || r <= done_r));
      check("done",  bus.done, (r == done_r));
      check("ready", bus.in_ready, exp_rdy);
      check("leak",  bus.lr_leak_factor_out, (r >= 1) ? factor : prev_factor);
      check("v1",    bus.lr_valid_1_out, exp_v1);
      check("v2",    bus.lr_valid_2_out, exp_v2);
      check("d1",    bus.lr_data_1_out, m_d1);
      check("d2",    bus.lr_data_2_out, m_d2);

      if (r == abort_r) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        drive_idle();
        m_d1 = '0; m_d2 = '0; factor = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        finished = 1'b1;
        break;
      end
      if (done_r >= 0 && r == done_r + 1) begin
        finished = 1'b1;
        break;
      end
    end
    check("job_finished", finished, 1);
    m_factor = factor;
    drive_idle();
  endtask

  int d;

  initial begin
    drive_idle();
    bus.cfg_rows        = '0;
    bus.cfg_leak_factor = '0;
    bus.in_data_1       = '0;
    bus.in_data_2       = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check_zero("reset");
    #2 rst_n = 1'b1;

    // reset applied mid-STREAM, then a normal rows=3 job
    run_job(10, DATA_W'($urandom), 1'b1, 16'hFFFF, 1'b0, 0, 5, d);
    check("abort_no_done", d, -1);
    run_job(3, 16'h0040, 1'b0, 16'h0, 1'b0, 0, -1, d);

    // minimum job, continuous input
    run_job(4, 16'h0033, 1'b1, 16'hFFFF, 1'b0, 0, -1, d);
    check("min_job_done_lat", d, 4 + 3 + L2);

    // empty job
    run_job(0, DATA_W'($urandom), 1'b0, 16'h0, 1'b0, 0, -1, d);
    check("zero_rows_done_lat", d, 2);

    // bubble pattern 1,0,1,0,1 then in_valid held high
    run_job(3, 16'h1234, 1'b1, 16'hFFF5, 1'b0, 0, -1, d);

    // start pulsed during STREAM is ignored
    run_job(5, 16'h0066, 1'b1, 16'hFFFF, 1'b0, 4, -1, d);
    check("inject_done_lat", d, 5 + 3 + L2);

    // excess lane-1 result pulses
    run_job(5, DATA_W'($urandom), 1'b0, 16'h0, 1'b1, 0, -1, d);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(0, 20), DATA_W'($urandom), 1'b0, 16'h0,
              1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 3 : 0, -1, d);
    end

    step();
    check("final_busy", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
